arbiter_rr_packet_mux: RTL and testbench

- Downstream consumer of the round-robin arbiter. It merges N valid/ready input streams into one output stream.
- It drives the arbiter's request vector and uses the returned grant_valid/grant_id to pick a source.
- It locks onto the granted source until that source's last beat, so packets never interleave.
- Output goes through a 2-entry registered skid FIFO, giving full throughput with no combinational m_ready->s_ready path.

---
 rtl/arbiter_rr_packet_mux.sv | 143 ++++++++++++++
 tb/tb_arbiter_rr_packet_mux.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_packet_mux.sv
// Packet-aware N:1 stream mux driven by an external round-robin arbiter.
// It locks onto a granted source until that source's last beat, then drains through a 2-entry skid FIFO.
module arbiter_rr_packet_mux #(
   parameter int N  = 4,
   parameter int W  = (N > 1) ? $clog2(N) : 1,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    s_valid,
   output logic [N-1:0]    s_ready,
   input  logic [N*DW-1:0] s_data,
   input  logic [N-1:0]    s_last,
   output logic [N-1:0]    arb_request,
   input  logic            arb_grant_valid,
   input  logic [W-1:0]    arb_grant_id,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_data,
   output logic            m_last,
   output logic [W-1:0]    m_src_id,
   output logic            busy
);

   typedef enum logic {IDLE, LOCKED} state_e;

   localparam int EW = DW + 1 + W;

   state_e          state_q, state_d;
   logic [W-1:0]    lock_id_q, lock_id_d;
   logic [1:0]      count_q, count_d;
   logic [EW-1:0]   head_q, tail_q;

   logic            can_accept;
   logic            push, pop;
   logic [W-1:0]    sel;
   logic            sel_ok;
   logic            push_last;
   logic [DW-1:0]   push_data;
   logic [EW-1:0]   push_entry;
   logic [DW-1:0]   src_data [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_src
      assign src_data[gi] = s_data[gi*DW +: DW];
   end

   // No same-cycle slot reuse: keeps m_ready off the s_ready path.
   assign can_accept = (count_q != 2'd2);
   assign pop        = (count_q != 2'd0) && m_ready;

   always_comb begin
      sel       = (state_q == LOCKED) ? lock_id_q : arb_grant_id;
      sel_ok    = (int'(sel) < N);
      push_data = sel_ok ? src_data[sel] : '0;
      push_last = sel_ok ? s_last[sel] : 1'b0;
   end

   assign push_entry = {push_data, push_last, sel};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      if (state_q == IDLE) begin
         if (push && !push_last) begin
            state_d   = LOCKED;
            lock_id_d = sel;
         end
      end else begin
         if (push && push_last) begin
            state_d = IDLE;
         end
      end
   end

   // Request only when a beat can be taken, so the arbiter pointer moves only on real transfers.
   always_comb begin
      s_ready     = '0;
      arb_request = '0;
      push        = 1'b0;
      if (rst_n) begin
         if (state_q == IDLE) begin
            if (can_accept) begin
               arb_request = s_valid;
               if (arb_grant_valid && sel_ok && s_valid[sel]) begin
                  s_ready[sel] = 1'b1;
                  push         = 1'b1;
               end
            end
         end else if (sel_ok && can_accept) begin
            s_ready[sel] = 1'b1;
            push         = s_valid[sel];
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   // Head entry drives m_* directly; push+pop only happens at count 1, so the new beat becomes head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push && pop) begin
            head_q <= push_entry;
         end else if (pop) begin
            head_q <= tail_q;
         end else if (push) begin
            if (count_q == 2'd0) begin
               head_q <= push_entry;
            end else begin
               tail_q <= push_entry;
            end
         end
      end
   end

   assign m_valid  = (count_q != 2'd0);
   assign m_data   = head_q[EW-1 -: DW];
   assign m_last   = head_q[W];
   assign m_src_id = head_q[W-1:0];
   assign busy     = (state_q == LOCKED) || (count_q != 2'd0);

endmodule

// File: tb/tb_arbiter_rr_packet_mux.sv
// Directed bench for arbiter_rr_packet_mux with a round-robin arbiter model and counting sources.
// Source i sends data {i[7:0], beat_seq[23:0]}; packet length per source is set by the stimulus.
module tb_arbiter_rr_packet_mux;

   localparam int N  = 4;
   localparam int W  = 2;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    s_valid;
   logic [N-1:0]    s_ready;
   logic [N*DW-1:0] s_data;
   logic [N-1:0]    s_last;
   logic [N-1:0]    arb_request;
   logic            arb_grant_valid;
   logic [W-1:0]    arb_grant_id;
   logic            m_valid;
   logic            m_ready;
   logic [DW-1:0]   m_data;
   logic            m_last;
   logic [W-1:0]    m_src_id;
   logic            busy;

   logic [N-1:0]    src_en;
   int              pkt_len [N];
   int              seq     [N];
   int              pos     [N];
   logic [W-1:0]    arb_last_q;

   int              n_checks;
   int              n_errors;

   arbiter_rr_packet_mux #(.N(N), .W(W), .DW(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_last          (s_last),
      .arb_request     (arb_request),
      .arb_grant_valid (arb_grant_valid),
      .arb_grant_id    (arb_grant_id),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_data          (m_data),
      .m_last          (m_last),
      .m_src_id        (m_src_id),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-robin arbiter: searches upward from the last granted index, pointer resets to 3.
   always_comb begin
      arb_grant_valid = 1'b0;
      arb_grant_id    = '0;
      for (int k = 1; k <= N; k++) begin
         if (!arb_grant_valid && arb_request[(int'(arb_last_q) + k) % N]) begin
            arb_grant_valid = 1'b1;
            arb_grant_id    = W'((int'(arb_last_q) + k) % N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_last_q <= 2'd3;
      end else if (arb_grant_valid) begin
         arb_last_q <= arb_grant_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            seq[i] <= 0;
            pos[i] <= 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (s_valid[i] && s_ready[i]) begin
               seq[i] <= seq[i] + 1;
               pos[i] <= (pos[i] >= pkt_len[i] - 1) ? 0 : pos[i] + 1;
            end
         end
      end
   end

   always_comb begin
      s_valid = src_en;
      s_data  = '0;
      s_last  = '0;
      for (int i = 0; i < N; i++) begin
         s_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
         s_last[i]          = (pos[i] == pkt_len[i] - 1);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      m_ready  = 1'b1;
      src_en   = 4'hF;
      for (int i = 0; i < N; i++) pkt_len[i] = 1;

      // Reset state
      #3;
      chk("rst_s_ready", 32'(s_ready), 32'h0);
      chk("rst_arb_req", 32'(arb_request), 32'h0);
      chk("rst_m_valid", 32'(m_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_m_data", m_data, 32'h0);
      chk("rst_m_src", 32'(m_src_id), 32'h0);

      // Single-beat round robin, 1 beat/cycle
      do_reset();
      chk("rr_s_ready0", 32'(s_ready), 32'h1);
      chk("rr_arb_req0", 32'(arb_request), 32'hF);
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("rr_valid_%0d", k), 32'(m_valid), 32'h1);
         chk($sformatf("rr_src_%0d", k), 32'(m_src_id), 32'(k % 4));
         chk($sformatf("rr_data_%0d", k), m_data, 32'(((k % 4) << 24) | (k / 4)));
      end
      chk("rr_busy", 32'(busy), 32'h1);

      // Packet lock: source 1 sends 3 beats while source 2 keeps requesting
      src_en = 4'b0110;
      pkt_len[1] = 3;
      do_reset();
      chk("lk_s_ready0", 32'(s_ready), 32'h2);
      chk("lk_arb_req0", 32'(arb_request), 32'h6);
      step();
      chk("lk_src_b1", 32'(m_src_id), 32'h1);
      chk("lk_data_b1", m_data, 32'h0100_0000);
      chk("lk_last_b1", 32'(m_last), 32'h0);
      chk("lk_arb_req_b2", 32'(arb_request), 32'h0);
      chk("lk_s_ready_b2", 32'(s_ready), 32'h2);
      step();
      chk("lk_src_b2", 32'(m_src_id), 32'h1);
      chk("lk_data_b2", m_data, 32'h0100_0001);
      chk("lk_arb_req_b3", 32'(arb_request), 32'h0);
      step();
      chk("lk_src_b3", 32'(m_src_id), 32'h1);
      chk("lk_data_b3", m_data, 32'h0100_0002);
      chk("lk_last_b3", 32'(m_last), 32'h1);
      chk("lk_s_ready_after", 32'(s_ready), 32'h4);
      step();
      chk("lk_src_next", 32'(m_src_id), 32'h2);
      chk("lk_data_next", m_data, 32'h0200_0000);

      // Backpressure: fill to 2, stall, then drain in order
      src_en  = 4'hF;
      pkt_len[1] = 1;
      m_ready = 1'b0;
      do_reset();
      chk("bp_s_ready0", 32'(s_ready), 32'h1);
      step();
      chk("bp_src_1", 32'(m_src_id), 32'h0);
      chk("bp_s_ready1", 32'(s_ready), 32'h2);
      step();
      chk("bp_full_s_ready", 32'(s_ready), 32'h0);
      chk("bp_full_arb_req", 32'(arb_request), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("bp_hold_data_%0d", k), m_data, 32'h0000_0000);
         chk($sformatf("bp_hold_sready_%0d", k), 32'(s_ready), 32'h0);
      end
      m_ready = 1'b1;
      #1;
      chk("bp_pop_no_push", 32'(s_ready), 32'h0);
      chk("bp_pop_no_req", 32'(arb_request), 32'h0);
      step();
      chk("bp_drain_src1", 32'(m_src_id), 32'h1);
      chk("bp_drain_data1", m_data, 32'h0100_0000);
      chk("bp_ptr_held", 32'(s_ready), 32'h4);
      step();
      chk("bp_src2", 32'(m_src_id), 32'h2);
      step();
      chk("bp_src3", 32'(m_src_id), 32'h3);
      step();
      chk("bp_src0", 32'(m_src_id), 32'h0);
      chk("bp_data0", m_data, 32'h0000_0001);

      // Reset during beat 2 of a 4-beat packet from source 3
      src_en = 4'b1000;
      pkt_len[3] = 4;
      do_reset();
      chk("rm_s_ready0", 32'(s_ready), 32'h8);
      step();
      step();
      chk("rm_busy_pre", 32'(busy), 32'h1);
      chk("rm_data_pre", m_data, 32'h0300_0001);
      rst_n = 1'b0;
      #1;
      chk("rm_async_valid", 32'(m_valid), 32'h0);
      chk("rm_async_busy", 32'(busy), 32'h0);
      chk("rm_async_sready", 32'(s_ready), 32'h0);
      chk("rm_async_req", 32'(arb_request), 32'h0);
      src_en = 4'hF;
      pkt_len[3] = 1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rm_first_grant", 32'(s_ready), 32'h1);
      step();
      chk("rm_first_src", 32'(m_src_id), 32'h0);

      // Source 0 idles for 5 cycles mid-packet
      src_en = 4'b0001;
      pkt_len[0] = 3;
      do_reset();
      chk("id_s_ready0", 32'(s_ready), 32'h1);
      step();
      src_en = 4'b1110;
      #1;
      chk("id_lock_sready", 32'(s_ready), 32'h1);
      chk("id_lock_req", 32'(arb_request), 32'h0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("id_gap_valid_%0d", k), 32'(m_valid), 32'h0);
         chk($sformatf("id_gap_sready_%0d", k), 32'(s_ready), 32'h1);
         chk($sformatf("id_gap_busy_%0d", k), 32'(busy), 32'h1);
      end
      src_en = 4'hF;
      #1;
      step();
      chk("id_b2_data", m_data, 32'h0000_0001);
      chk("id_b2_last", 32'(m_last), 32'h0);
      step();
      chk("id_b3_data", m_data, 32'h0000_0002);
      chk("id_b3_last", 32'(m_last), 32'h1);
      chk("id_unlock_sready", 32'(s_ready), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
